cart_mapper_gen: RTL and testbench
==================================

Name: cart_mapper_gen

Overview:
Parametrised, generalised cartridge bank mapper for the MSX cart slot. It covers linear, Konami, Konami SCC, ASCII8, ASCII16 and R-Type modes in one register file, with configurable bank count, bank width and address width. It translates CPU slot addresses into ROM addresses masked to rom_size. It also owns the read handshake toward the SDRAM/BRAM backend and stalls the CPU until read data is valid. It sits between the slot decode and the ROM storage, replacing the per-mapper address muxing.

Parameters:
ADDR_W, 25, ROM address width in bytes
BANK_W, 8, width of each bank register
NUM_BANKS, 4, number of 8 KB windows covering 0x4000-0xBFFF; only 4 is legal in this generation, asserted at elaboration

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
mode  in  3  0 linear, 1 Konami, 2 Konami SCC, 3 ASCII8, 4 ASCII16, 5 R-Type; 6-7 behave as linear
rom_size  in  ADDR_W  image size in bytes, power of two
cs  in  1  slot selected (~SLTSL_n)
addr  in  16  CPU address
wr  in  1  CPU write strobe, level
rd  in  1  CPU read strobe, level
d_from_cpu  in  8  CPU write data
d_to_cpu  out  8  latched read data
cpu_wait  out  1  high while a read is outstanding
mem_addr  out  ADDR_W  backend byte address
mem_rd  out  1  one-cycle read request
mem_ready  in  1  backend data valid, one cycle
mem_dout  in  8  backend read data

Behaviour:
- Reset (async, reset_n low): state IDLE; d_to_cpu=0x00; cpu_wait=0; mem_rd=0; mem_addr=0; banks loaded with mode defaults.
- Mode defaults: Konami/SCC banks 0,1,2,3; ASCII8/ASCII16 all 0; R-Type bank0=0x0F, bank1=0.
- Mode change: mode is registered each cycle. On the first cycle mode differs from the registered copy, banks reload the defaults. Any write in that cycle is dropped.
- Bank writes happen on the rising edge of wr&cs; one write per wr assertion. Decode by mode:
  - Konami: 6000-67FF, 8000-87FF and A000-A7FF write banks 1, 2 and 3; bank0 fixed at 0.
  - SCC: 5000-57FF, 7000-77FF, 9000-97FF and B000-B7FF write banks 0-3.
  - ASCII8: 6000, 6800, 7000 and 7800 (2 KB each) write banks 0-3.
  - ASCII16: 6000-67FF writes bank0 (16 KB, 4000-7FFF); 7000-77FF writes bank1 (8000-BFFF).
  - R-Type: 7000-7FFF writes bank1 with d&0x17; bank0 fixed 0x0F.
  - Linear: no registers.
- Address generation:
  - 8 KB modes: window = addr[14:13]-2 mod 4, i.e. 4000→0 … A000→3; mem_addr = {bank[window], addr[12:0]}.
  - 16 KB modes: {bank[addr[15]^addr[14]?..], addr[13:0]}, with page 4000-7FFF using bank0 and 8000-BFFF using bank1.
  - Linear: mem_addr = addr.
  - All modes: mem_addr &= rom_size-1. Bank bits above ADDR_W are truncated.
- Out-of-window reads (addr<0x4000 or ≥0xC000, non-linear modes): no request issued; d_to_cpu=0xFF; cpu_wait stays 0.
- Read FSM:
  - IDLE: on rising edge of rd&cs in a valid window, latch mem_addr, pulse mem_rd for one cycle, set cpu_wait=1, go to WAIT.
  - WAIT: on mem_ready, d_to_cpu←mem_dout, cpu_wait=0, go to HOLD.
  - HOLD: stay until rd falls, then IDLE. No retrigger while rd is held.
- mem_ready is ignored outside WAIT.
- mem_addr is stable from the mem_rd cycle until mem_ready.
- Bank writes during WAIT update the registers but do not alter the latched mem_addr.
- Simultaneous rd and wr rising: the write is taken and no read request is issued.
- Read latency: mem_rd asserts 1 cycle after the rd edge; cpu_wait falls in the cycle after mem_ready.
- Reset mid-WAIT returns to IDLE with cpu_wait=0. A late mem_ready after reset is ignored.

Optional Feature:
CART_MAPPER_SRAM_EN:
- Defined: ASCII8 modes treat a bank write with bit (BANK_W-1) set as selecting 8 KB battery SRAM for that window. Reads to that window are served from an internal sram_* port set (sram_addr[12:0], sram_we, sram_q), with no backend request and zero wait. CPU writes to an SRAM-mapped window in 8000-BFFF assert sram_we.
- Undefined: no SRAM ports exist, and bank bit (BANK_W-1) is ordinary address.

Decomposition:
- Shared package cart_pkg: mode enum (MODE_LINEAR … MODE_RTYPE), FSM state enum (IDLE/WAIT/HOLD), window base constants, default bank tables.
- One sub-module, cart_bank_regs: write decode, bank register file and mode-change reload. The top level keeps address generation and the read FSM.

Test Plan:
- Reset, mode=1, read 0x8000 with rom_size=0x20000 → mem_addr=0x04000, mem_rd one cycle, cpu_wait until mem_ready; d_to_cpu=mem_dout.
- Mode=2, write 0x9000←0x05, read 0x9123 → mem_addr=0x0B123.
- Mode=4, write 0x7000←0x1F, rom_size=0x40000, read 0x8001 → mem_addr=(0x1F<<14 | 1)&0x3FFFF=0x3C001.
- Mode=5, write 0x7800←0xFF, read 0x4000 → 0x3C000; read 0x8000 → 0x5C000 (0x17 bank), masked by rom_size.
- Reset asserted in WAIT, then mem_ready pulse → cpu_wait=0, d_to_cpu=0x00, no state change.
- Read 0x2000 in mode 3 → no mem_rd, d_to_cpu=0xFF; change mode 3→1 → banks become 0,1,2,3.

Source files
------------

// File: rtl/cart_pkg.sv
// Shared types and constants for the generalised MSX cartridge bank mapper.
package cart_pkg;

  typedef enum logic [2:0] {
    MODE_LINEAR  = 3'd0,
    MODE_KONAMI  = 3'd1,
    MODE_SCC     = 3'd2,
    MODE_ASCII8  = 3'd3,
    MODE_ASCII16 = 3'd4,
    MODE_RTYPE   = 3'd5
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Banked modes only answer inside 4000-BFFF.
  localparam logic [15:0] WIN_BASE = 16'h4000;
  localparam logic [15:0] WIN_END  = 16'hC000;

  localparam logic [3:0][7:0] DEF_8K    = {8'd3, 8'd2, 8'd1, 8'd0};
  localparam logic [3:0][7:0] DEF_RTYPE = {8'd0, 8'd0, 8'd0, 8'h0F};

  // Codes 6 and 7 are not mappers and fall back to linear.
  function automatic mode_e decode_mode(input logic [2:0] m);
    case (m)
      3'd1:    return MODE_KONAMI;
      3'd2:    return MODE_SCC;
      3'd3:    return MODE_ASCII8;
      3'd4:    return MODE_ASCII16;
      3'd5:    return MODE_RTYPE;
      default: return MODE_LINEAR;
    endcase
  endfunction

  function automatic logic [3:0][7:0] default_banks(input mode_e m);
    case (m)
      MODE_KONAMI, MODE_SCC: return DEF_8K;
      MODE_RTYPE:            return DEF_RTYPE;
      default:               return '0;
    endcase
  endfunction

endpackage

// File: rtl/cart_mapper_gen_if.sv
// CPU slot and ROM backend signals of the cartridge mapper; the SRAM port set
// exists only when CART_MAPPER_SRAM_EN is defined.
interface cart_mapper_gen_if #(
  parameter int ADDR_W = 25
);
  logic              cs;
  logic [15:0]       addr;
  logic              wr;
  logic              rd;
  logic [7:0]        d_from_cpu;
  logic [7:0]        d_to_cpu;
  logic              cpu_wait;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_ready;
  logic [7:0]        mem_dout;
`ifdef CART_MAPPER_SRAM_EN
  logic [12:0]       sram_addr;
  logic              sram_we;
  logic [7:0]        sram_q;

  modport slave (
    input  cs, addr, wr, rd, d_from_cpu, mem_ready, mem_dout, sram_q,
    output d_to_cpu, cpu_wait, mem_addr, mem_rd, sram_addr, sram_we
  );
  modport master (
    output cs, addr, wr, rd, d_from_cpu, mem_ready, mem_dout, sram_q,
    input  d_to_cpu, cpu_wait, mem_addr, mem_rd, sram_addr, sram_we
  );
`else
  modport slave (
    input  cs, addr, wr, rd, d_from_cpu, mem_ready, mem_dout,
    output d_to_cpu, cpu_wait, mem_addr, mem_rd
  );
  modport master (
    output cs, addr, wr, rd, d_from_cpu, mem_ready, mem_dout,
    input  d_to_cpu, cpu_wait, mem_addr, mem_rd
  );
`endif
endinterface

// File: rtl/cart_bank_regs.sv
// Bank register file: per-mode write decode, one write per wr assertion, and
// reload of the mode's default banks whenever the mode input changes.
module cart_bank_regs import cart_pkg::*; #(
  parameter int BANK_W    = 8,
  parameter int NUM_BANKS = 4
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [2:0]                        mode,
  input  logic                              cs,
  input  logic                              wr,
  input  logic [15:11]                      addr_hi,
  input  logic [7:0]                        d,
  output logic                              wr_rise,
  output logic [NUM_BANKS-1:0][BANK_W-1:0]  bank
);

  mode_e            m;
  logic [2:0]       mode_p1;
  logic             wr_p1;
  logic             init_p1;
  logic             reload;
  logic [3:0][7:0]  defs;
  logic             sel_vld;
  logic [1:0]       sel_idx;
  logic [BANK_W-1:0] sel_val;

  assign m       = decode_mode(mode);
  assign wr_rise = wr & cs & ~wr_p1;
  // init_p1 forces one reload straight after reset so banks track the mode.
  assign reload  = ~init_p1 | (mode != mode_p1);
  assign defs    = default_banks(m);

  always_comb begin
    sel_vld = 1'b0;
    sel_idx = 2'd0;
    sel_val = BANK_W'(d);
    case (m)
      MODE_KONAMI: begin
        case (addr_hi)
          5'h0C: begin sel_vld = 1'b1; sel_idx = 2'd1; end
          5'h10: begin sel_vld = 1'b1; sel_idx = 2'd2; end
          5'h14: begin sel_vld = 1'b1; sel_idx = 2'd3; end
          default: ;
        endcase
      end
      MODE_SCC: begin
        case (addr_hi)
          5'h0A: begin sel_vld = 1'b1; sel_idx = 2'd0; end
          5'h0E: begin sel_vld = 1'b1; sel_idx = 2'd1; end
          5'h12: begin sel_vld = 1'b1; sel_idx = 2'd2; end
          5'h16: begin sel_vld = 1'b1; sel_idx = 2'd3; end
          default: ;
        endcase
      end
      MODE_ASCII8: begin
        if (addr_hi[15:13] == 3'b011) begin
          sel_vld = 1'b1;
          sel_idx = addr_hi[12:11];
        end
      end
      MODE_ASCII16: begin
        case (addr_hi)
          5'h0C: begin sel_vld = 1'b1; sel_idx = 2'd0; end
          5'h0E: begin sel_vld = 1'b1; sel_idx = 2'd1; end
          default: ;
        endcase
      end
      MODE_RTYPE: begin
        if (addr_hi[15:12] == 4'h7) begin
          sel_vld = 1'b1;
          sel_idx = 2'd1;
          sel_val = BANK_W'(d & 8'h17);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_p1   <= 1'b0;
      init_p1 <= 1'b0;
      mode_p1 <= 3'd0;
      bank    <= '0;
    end else begin
      wr_p1   <= wr & cs;
      init_p1 <= 1'b1;
      mode_p1 <= mode;
      if (reload) begin
        for (int i = 0; i < NUM_BANKS; i++) bank[i] <= BANK_W'(defs[i]);
      end else if (wr_rise && sel_vld) begin
        bank[sel_idx] <= sel_val;
      end
    end
  end

endmodule

// File: rtl/cart_mapper_gen.sv
// Generalised MSX cartridge mapper: slot-to-ROM address translation and the
// backend read handshake. Optional battery SRAM via CART_MAPPER_SRAM_EN.
module cart_mapper_gen import cart_pkg::*; #(
  parameter int ADDR_W    = 25,
  parameter int BANK_W    = 8,
  parameter int NUM_BANKS = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        mode,
  input  logic [ADDR_W-1:0] rom_size,
  cart_mapper_gen_if.slave  bus
);

  localparam int WIDE_W = ADDR_W + BANK_W + 16;

  generate
    if (NUM_BANKS != 4) begin : g_num_banks_chk
      $error("cart_mapper_gen: NUM_BANKS must be 4");
    end
  endgenerate

  mode_e                             m;
  logic                              wr_rise;
  logic [NUM_BANKS-1:0][BANK_W-1:0]  bank;
  logic                              rd_cs;
  logic                              rd_p1;
  logic                              rd_rise;
  logic                              in_win;
  logic [1:0]                        win;
  logic [BANK_W-1:0]                 win_bank;
  logic [WIDE_W-1:0]                 wide;
  logic [ADDR_W-1:0]                 addr_gen;
  state_e                            state;
  logic [7:0]                        d_out;
  logic                              wait_out;
  logic                              mem_rd_out;
  logic [ADDR_W-1:0]                 mem_addr_out;

  assign m       = decode_mode(mode);
  assign rd_cs   = bus.rd & bus.cs;
  assign rd_rise = rd_cs & ~rd_p1;
  assign in_win  = (m == MODE_LINEAR) ||
                   ((bus.addr >= WIN_BASE) && (bus.addr < WIN_END));

  cart_bank_regs #(
    .BANK_W    (BANK_W),
    .NUM_BANKS (NUM_BANKS)
  ) u_bank_regs (
    .clk     (clk),
    .reset_n (reset_n),
    .mode    (mode),
    .cs      (bus.cs),
    .wr      (bus.wr),
    .addr_hi (bus.addr[15:11]),
    .d       (bus.d_from_cpu),
    .wr_rise (wr_rise),
    .bank    (bank)
  );

  // Window 0 starts at 4000, so subtracting 2 from addr[14:13] rotates A15:A13.
  always_comb begin
    win      = bus.addr[14:13] - 2'd2;
    win_bank = bank[win];
`ifdef CART_MAPPER_SRAM_EN
    if (m == MODE_ASCII8) win_bank[BANK_W-1] = 1'b0;
`endif
    case (m)
      MODE_KONAMI, MODE_SCC, MODE_ASCII8:
        wide = {{(ADDR_W+3){1'b0}}, win_bank, bus.addr[12:0]};
      MODE_ASCII16, MODE_RTYPE:
        wide = {{(ADDR_W+2){1'b0}}, (bus.addr[15] ? bank[1] : bank[0]), bus.addr[13:0]};
      default:
        wide = {{(ADDR_W+BANK_W){1'b0}}, bus.addr};
    endcase
    addr_gen = wide[ADDR_W-1:0] & (rom_size - ADDR_W'(1));
  end

`ifdef CART_MAPPER_SRAM_EN
  logic sram_hit;
  assign sram_hit      = (m == MODE_ASCII8) && in_win && bank[win][BANK_W-1];
  assign bus.sram_addr = bus.addr[12:0];
  assign bus.sram_we   = bus.wr & bus.cs & sram_hit & bus.addr[15];
`endif

  // Read handshake; a write edge in the same cycle wins over a read edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      rd_p1        <= 1'b0;
      d_out        <= 8'h00;
      wait_out     <= 1'b0;
      mem_rd_out   <= 1'b0;
      mem_addr_out <= '0;
    end else begin
      rd_p1      <= rd_cs;
      mem_rd_out <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_rise && !wr_rise) begin
            if (!in_win) begin
              d_out <= 8'hFF;
              state <= HOLD;
`ifdef CART_MAPPER_SRAM_EN
            end else if (sram_hit) begin
              d_out <= bus.sram_q;
              state <= HOLD;
`endif
            end else begin
              mem_addr_out <= addr_gen;
              mem_rd_out   <= 1'b1;
              wait_out     <= 1'b1;
              state        <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.mem_ready) begin
            d_out    <= bus.mem_dout;
            wait_out <= 1'b0;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (!rd_cs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.d_to_cpu = d_out;
  assign bus.cpu_wait = wait_out;
  assign bus.mem_rd   = mem_rd_out;
  assign bus.mem_addr = mem_addr_out;

endmodule

// File: tb/tb_cart_mapper_gen.sv
// Randomised bench for cart_mapper_gen against a behavioural mapper model.
module tb_cart_mapper_gen;

  localparam int ADDR_W = 25;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [2:0]        mode;
  logic [ADDR_W-1:0] rom_size;

  cart_mapper_gen_if #(.ADDR_W(ADDR_W)) bus ();

  cart_mapper_gen #(
    .ADDR_W    (ADDR_W),
    .BANK_W    (8),
    .NUM_BANKS (4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .mode     (mode),
    .rom_size (rom_size),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  int                n_vec = 0;
  int                n_err = 0;
  int                mbank [4];
  int                mode_cur;
  bit                chk_en = 1'b0;
  logic [7:0]        exp_d;
  logic              exp_wait;
  logic              exp_rd;
  logic [ADDR_W-1:0] exp_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cpu_wait", 64'(bus.cpu_wait), 64'(exp_wait));
      chk("mem_rd",   64'(bus.mem_rd),   64'(exp_rd));
      chk("d_to_cpu", 64'(bus.d_to_cpu), 64'(exp_d));
      chk("mem_addr", 64'(bus.mem_addr), 64'(exp_addr));
    end
  end

  // ---------------- behavioural model ----------------
  function automatic void model_defaults();
    for (int i = 0; i < 4; i++) mbank[i] = 0;
    if (mode_cur == 1 || mode_cur == 2) for (int i = 0; i < 4; i++) mbank[i] = i;
    if (mode_cur == 5) mbank[0] = 'h0F;
  endfunction

  function automatic void model_write(input int a, input int d);
    case (mode_cur)
      1: begin
        if (a >= 'h6000 && a < 'h6800) mbank[1] = d;
        if (a >= 'h8000 && a < 'h8800) mbank[2] = d;
        if (a >= 'hA000 && a < 'hA800) mbank[3] = d;
      end
      2: for (int i = 0; i < 4; i++)
           if (a >= 'h5000 + i * 'h2000 && a < 'h5800 + i * 'h2000) mbank[i] = d;
      3: if (a >= 'h6000 && a < 'h8000) mbank[(a - 'h6000) / 'h800] = d;
      4: begin
        if (a >= 'h6000 && a < 'h6800) mbank[0] = d;
        if (a >= 'h7000 && a < 'h7800) mbank[1] = d;
      end
      5: if (a >= 'h7000 && a < 'h8000) mbank[1] = d & 'h17;
      default: ;
    endcase
  endfunction

  function automatic bit model_in_win(input int a);
    return (mode_cur == 0 || mode_cur > 5) || (a >= 'h4000 && a < 'hC000);
  endfunction

  function automatic longint model_addr(input int a);
    longint r;
    if (mode_cur >= 1 && mode_cur <= 3)
      r = longint'(mbank[(a - 'h4000) / 'h2000]) * 'h2000 + a % 'h2000;
    else if (mode_cur == 4 || mode_cur == 5)
      r = longint'(mbank[(a < 'h8000) ? 0 : 1]) * 'h4000 + a % 'h4000;
    else
      r = a;
    return r % longint'(rom_size);
  endfunction

  // ---------------- drivers (start and end 1 time unit after posedge) -------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input int m);
    mode = 3'(m);
    if (m != mode_cur) begin
      mode_cur = m;
      model_defaults();
    end
    tick();
    tick();
  endtask

  task automatic do_write(input int a, input int d);
    bus.cs = 1'b1; bus.wr = 1'b1; bus.addr = 16'(a); bus.d_from_cpu = 8'(d);
    tick();
    model_write(a, d);
    bus.wr = 1'b0; bus.cs = 1'b0;
    tick();
  endtask

  task automatic do_read(input int a, input int dat, input int lat,
                         input bit mw, input int mwa, input int mwd);
    bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = 16'(a);
    tick();
    if (!model_in_win(a)) begin
      exp_d = 8'hFF;
      bus.rd = 1'b0; bus.cs = 1'b0;
      tick();
      return;
    end
    exp_rd = 1'b1; exp_wait = 1'b1; exp_addr = ADDR_W'(model_addr(a));
    tick();
    exp_rd = 1'b0;
    if (mw) begin
      bus.wr = 1'b1; bus.addr = 16'(mwa); bus.d_from_cpu = 8'(mwd);
      tick();
      model_write(mwa, mwd);
      bus.wr = 1'b0;
    end
    repeat (lat) tick();
    bus.mem_ready = 1'b1; bus.mem_dout = 8'(dat);
    tick();
    bus.mem_ready = 1'b0;
    exp_wait = 1'b0; exp_d = 8'(dat);
    tick();
    bus.rd = 1'b0; bus.cs = 1'b0;
    tick();
  endtask

  task automatic do_rdwr(input int a, input int d);
    bus.cs = 1'b1; bus.rd = 1'b1; bus.wr = 1'b1; bus.addr = 16'(a); bus.d_from_cpu = 8'(d);
    tick();
    model_write(a, d);
    bus.rd = 1'b0; bus.wr = 1'b0; bus.cs = 1'b0;
    tick();
  endtask

  function automatic int pick_wr_addr();
    int bases [9] = '{'h5000, 'h6000, 'h6800, 'h7000, 'h7800, 'h8000, 'h9000, 'hA000, 'hB000};
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(0, 'hFFFF));
    return bases[$urandom_range(0, 8)] + int'($urandom_range(0, 'h7FF));
  endfunction

  function automatic int pick_rd_addr();
    if ($urandom_range(0, 6) == 0) return int'($urandom_range(0, 'hFFFF));
    return int'($urandom_range('h4000, 'hBFFF));
  endfunction

  initial begin
    int sel;
    reset_n = 1'b0; mode = 3'd0; mode_cur = 0; rom_size = ADDR_W'(32'h20000);
    bus.cs = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0; bus.addr = 16'h0; bus.d_from_cpu = 8'h0;
    bus.mem_ready = 1'b0; bus.mem_dout = 8'h0;
    exp_d = 8'h00; exp_wait = 1'b0; exp_rd = 1'b0; exp_addr = '0;
    model_defaults();
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    tick(); tick();

    // Konami defaults: 8000 sits in bank 2.
    set_mode(1);
    do_read('h8000, 'h5A, 2, 1'b0, 0, 0);
    chk("konami_addr", 64'(bus.mem_addr), 64'h04000);
    chk("konami_data", 64'(bus.d_to_cpu), 64'h5A);

    set_mode(2);
    do_write('h9000, 'h05);
    do_read('h9123, 'hC3, 1, 1'b0, 0, 0);
    chk("scc_addr", 64'(bus.mem_addr), 64'h0B123);

    set_mode(4);
    do_write('h7000, 'h1F);
    rom_size = ADDR_W'(32'h40000);
    do_read('h8001, 'h11, 0, 1'b0, 0, 0);
    chk("ascii16_addr", 64'(bus.mem_addr), 64'h3C001);

    set_mode(5);
    rom_size = ADDR_W'(32'h80000);
    do_write('h7800, 'hFF);
    do_read('h4000, 'h22, 1, 1'b0, 0, 0);
    chk("rtype_bank0", 64'(bus.mem_addr), 64'h3C000);
    do_read('h8000, 'h33, 3, 1'b0, 0, 0);
    chk("rtype_bank1", 64'(bus.mem_addr), 64'h5C000);

    // Reset while waiting on the backend, then a late mem_ready.
    set_mode(1);
    rom_size = ADDR_W'(32'h20000);
    bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = 16'hA000;
    tick();
    exp_rd = 1'b1; exp_wait = 1'b1; exp_addr = ADDR_W'(model_addr('hA000));
    tick();
    exp_rd = 1'b0;
    reset_n = 1'b0; bus.rd = 1'b0; bus.cs = 1'b0;
    exp_wait = 1'b0; exp_d = 8'h00; exp_addr = '0;
    tick(); tick();
    reset_n = 1'b1;
    model_defaults();
    bus.mem_ready = 1'b1; bus.mem_dout = 8'hEE;
    tick();
    bus.mem_ready = 1'b0;
    tick();
    chk("rst_wait", 64'(bus.cpu_wait), 64'h0);
    chk("rst_data", 64'(bus.d_to_cpu), 64'h00);

    // Out-of-window read, then mode change restores Konami defaults.
    set_mode(3);
    do_read('h2000, 'h44, 1, 1'b0, 0, 0);
    chk("oow_data", 64'(bus.d_to_cpu), 64'hFF);
    do_write('h6000, 'h07);
    do_write('h7800, 'h09);
    set_mode(1);
    do_read('hA000, 'h55, 1, 1'b0, 0, 0);
    chk("reload_b3", 64'(bus.mem_addr), 64'h06000);
    do_read('h4000, 'h56, 1, 1'b0, 0, 0);
    chk("reload_b0", 64'(bus.mem_addr), 64'h00000);

    // Read and write edges together: only the write is taken.
    set_mode(2);
    do_rdwr('h9000, 'h09);
    do_read('h8000, 'h66, 1, 1'b0, 0, 0);
    chk("rdwr_addr", 64'(bus.mem_addr), 64'h12000);

    // Bank write while waiting must not disturb the latched address.
    do_read('hB000, 'h77, 2, 1'b1, 'hB000, 'h0A);
    chk("midwr_addr", 64'(bus.mem_addr), 64'h07000);
    do_read('hB000, 'h78, 1, 1'b0, 0, 0);
    chk("midwr_after", 64'(bus.mem_addr), 64'h15000);

    // rd without cs does nothing.
    bus.rd = 1'b1;
    tick(); tick();
    bus.rd = 1'b0;
    tick();

    set_mode(0);
    rom_size = ADDR_W'(32'h10000);
    do_read('h1234, 'h99, 1, 1'b0, 0, 0);
    chk("linear_addr", 64'(bus.mem_addr), 64'h01234);

    for (int it = 0; it < 400; it++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 8) begin
        rom_size = ADDR_W'(1) << $urandom_range(14, 22);
        set_mode(int'($urandom_range(0, 7)));
      end else if (sel < 35) begin
        do_write(pick_wr_addr(), int'($urandom_range(0, 255)));
      end else if (sel < 90) begin
        do_read(pick_rd_addr(), int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 9) == 0), pick_wr_addr(), int'($urandom_range(0, 255)));
      end else begin
        bus.mem_ready = 1'b1; bus.mem_dout = 8'($urandom_range(0, 255));
        tick();
        bus.mem_ready = 1'b0;
        tick();
      end
    end

    tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
